// File: rtl/kws_layer_sequencer.sv
// kws_layer_sequencer
// Steps through a small program of layer opcodes, enabling one KWS datapath
// stage at a time, waiting for its completion with a per-stage timeout, and
// reporting program completion (done pulse) or a timeout (sticky error).
// Opcode format: [2:0] stage index, [4:3] systolic op.
module kws_layer_sequencer #(
  parameter int PROG_DEPTH = 8,
  parameter int AW         = 3,
  parameter int TW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [4:0]    cfg_wdata,
  input  logic [AW:0]   prog_len,
  input  logic [TW-1:0] timeout_limit,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    stage_done,
  output logic [7:0]    stage_en,
  output logic [1:0]    systolic_op,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int LW = AW + 1;
  localparam logic [AW:0] DEPTH_L = LW'(PROG_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Registered state and outputs
  state_t        r_state;
  logic [4:0]    r_mem [PROG_DEPTH];
  logic [AW:0]   r_len;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_stage_en;
  logic [1:0]    r_sys_op;
  logic [AW-1:0] r_pc;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  // Next-state values
  state_t        w_state;
  logic [AW:0]   w_len;
  logic [TW-1:0] w_tcnt;
  logic [7:0]    w_stage_en;
  logic [1:0]    w_sys_op;
  logic [AW-1:0] w_pc;
  logic          w_done;
  logic          w_error;

  // Helpers
  logic [AW:0]   w_len_clamped;
  logic [4:0]    w_instr;
  logic          w_hit;
  logic          w_last;
  logic          w_tmo;

  // Program length beyond the memory depth runs the whole memory
  assign w_len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign w_instr       = r_mem[r_pc];
  // Only the done bit of the currently enabled stage counts
  assign w_hit         = |(stage_done & r_stage_en);
  assign w_last        = ({1'b0, r_pc} == (r_len - 1'b1));
  assign w_tmo         = (timeout_limit != '0) && (r_tcnt == (timeout_limit - 1'b1));

  // Program memory: host writes accepted only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (cfg_we && (r_state == S_IDLE)) begin
      r_mem[cfg_addr] <= cfg_wdata;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_len      = r_len;
    w_tcnt     = r_tcnt;
    w_stage_en = r_stage_en;
    w_sys_op   = r_sys_op;
    w_pc       = r_pc;
    w_done     = 1'b0;
    w_error    = r_error;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_error = 1'b0;
          if (w_len_clamped == '0) begin
            // Empty program completes immediately without leaving IDLE
            w_done = 1'b1;
          end else begin
            w_state = S_FETCH;
            w_pc    = '0;
            w_len   = w_len_clamped;
          end
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_state    = S_IDLE;
          w_stage_en = '0;
        end else begin
          w_state    = S_RUN;
          w_stage_en = 8'(1) << w_instr[2:0];
          w_sys_op   = w_instr[4:3];
          w_tcnt     = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state    = S_IDLE;
          w_stage_en = '0;
        end else if (w_hit) begin
          // Completion takes precedence over a coincident timeout
          w_stage_en = '0;
          if (w_last) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = S_FETCH;
            w_pc    = r_pc + 1'b1;
          end
        end else if (w_tmo) begin
          w_state    = S_IDLE;
          w_stage_en = '0;
          w_error    = 1'b1;
        end else begin
          w_tcnt = r_tcnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state    = S_IDLE;
        w_stage_en = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_tcnt     <= '0;
      r_stage_en <= '0;
      r_sys_op   <= '0;
      r_pc       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_len      <= w_len;
      r_tcnt     <= w_tcnt;
      r_stage_en <= w_stage_en;
      r_sys_op   <= w_sys_op;
      r_pc       <= w_pc;
      r_busy     <= (w_state != S_IDLE);
      r_done     <= w_done;
      r_error    <= w_error;
    end
  end

  assign stage_en    = r_stage_en;
  assign systolic_op = r_sys_op;
  assign pc          = r_pc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: tb/tb_kws_layer_sequencer.sv
// Testbench for kws_layer_sequencer: table-driven programs checked through
// a stage-enable scoreboard, plus hand-written timing, timeout, abort,
// ignored-write and reset sequences.
module tb_kws_layer_sequencer;

  localparam int PROG_DEPTH = 8;
  localparam int AW         = 3;
  localparam int TW         = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [4:0]    cfg_wdata;
  logic [AW:0]   prog_len;
  logic [TW-1:0] timeout_limit;
  logic          start;
  logic          abort;
  logic [7:0]    stage_done;
  logic [7:0]    stage_en;
  logic [1:0]    systolic_op;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          error;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] en;
    logic [1:0] op;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [14:0] prog;
    int          len;
    logic [23:0] en;
    logic [5:0]  op;
  } vec_t;
  vec_t vecs[4];

  int resp_delay = 4;
  bit stray_en   = 1'b0;

  kws_layer_sequencer #(.PROG_DEPTH(PROG_DEPTH), .AW(AW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .prog_len(prog_len), .timeout_limit(timeout_limit),
    .start(start), .abort(abort), .stage_done(stage_done),
    .stage_en(stage_en), .systolic_op(systolic_op), .pc(pc), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every rising stage_en must match the next queued expectation
  initial begin
    logic [7:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
      end else begin
        if (stage_en != 8'h00 && prev == 8'h00) begin
          if (exp_q.size() == 0) begin
            chk("unexpected stage_en", {24'h0, stage_en}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("sb stage_en", {24'h0, stage_en}, {24'h0, e.en});
            chk("sb systolic_op", {30'h0, systolic_op}, {30'h0, e.op});
          end
        end
        prev = stage_en;
      end
    end
  end

  // Datapath model: returns stage_done resp_delay cycles into each enable
  initial begin
    int cnt;
    cnt = 0;
    stage_done = '0;
    forever begin
      @(negedge clk);
      if (stage_en != 8'h00) cnt++;
      else cnt = 0;
      stage_done = (resp_delay != 0 && cnt == resp_delay) ? stage_en : 8'h00;
      if (stray_en && stage_en == 8'h02) stage_done = stage_done | 8'h20;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [14:0] prog, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_addr  = AW'(i);
      cfg_wdata = prog[5*i +: 5];
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic push_exp(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      exp_q.push_back({v.en[8*i +: 8], v.op[2*i +: 2]});
    end
  endtask

  // Leaves the bench at the negedge right after start was sampled
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " done reached"}, {31'h0, (n < 300)}, 32'h1);
    chk({nm, " scoreboard drained"}, exp_q.size(), 32'h0);
  endtask

  initial begin
    int   hi;
    int   dn;
    int   n;
    logic [7:0] e_en;

    vecs[0] = '{prog: {5'b00010, 5'b00001, 5'b00000}, len: 3,
                en: {8'h04, 8'h02, 8'h01}, op: {2'd0, 2'd0, 2'd0}};
    vecs[1] = '{prog: {5'b00101, 5'b01100, 5'b10111}, len: 3,
                en: {8'h20, 8'h10, 8'h80}, op: {2'd0, 2'd1, 2'd2}};
    vecs[2] = '{prog: {5'b00000, 5'b00011, 5'b00110}, len: 2,
                en: {8'h00, 8'h08, 8'h40}, op: {2'd0, 2'd0, 2'd0}};
    vecs[3] = '{prog: {10'b0, 5'b11111}, len: 1,
                en: {16'h0, 8'h80}, op: {4'h0, 2'd3}};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    prog_len = '0; timeout_limit = '0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset stage_en", {24'h0, stage_en}, 32'h0);
    chk("reset pc/op", {27'h0, pc, systolic_op}, 32'h0);
    chk("reset busy/done/error", {29'h0, busy, done, error}, 32'h0);
    rst_n = 1'b1;

    // Cycle-exact run of {cmvn, linear, relu}: 1 fetch + 4 run cycles each
    load(vecs[0].prog, 3);
    prog_len = 4'd3;
    push_exp(vecs[0]);
    pulse_start();
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      e_en = (k < 15 && (k % 5) != 0) ? (8'h01 << (k / 5)) : 8'h00;
      chk($sformatf("seqA stage_en k=%0d", k), {24'h0, stage_en}, {24'h0, e_en});
      chk($sformatf("seqA busy k=%0d", k), {31'h0, busy}, {31'h0, (k <= 15)});
      chk($sformatf("seqA done k=%0d", k), {31'h0, done}, {31'h0, (k == 15)});
    end
    chk("seqA pc holds", {29'h0, pc}, 32'd2);

    // Table of programs through the scoreboard
    for (int v = 0; v < 4; v++) begin
      load(vecs[v].prog, vecs[v].len);
      prog_len = 4'(vecs[v].len);
      push_exp(vecs[v]);
      pulse_start();
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d final pc", v), {29'h0, pc}, 32'(vecs[v].len - 1));
      @(negedge clk);
      chk($sformatf("vec%0d busy after", v), {31'h0, busy}, 32'h0);
    end

    // Empty program
    prog_len = 4'd0;
    pulse_start();
    chk("len0 done", {31'h0, done}, 32'h1);
    chk("len0 busy", {31'h0, busy}, 32'h0);
    chk("len0 stage_en", {24'h0, stage_en}, 32'h0);
    @(negedge clk);
    chk("len0 done single", {31'h0, done}, 32'h0);

    // Timeout after 10 run cycles, no completion
    load(15'b0, 1);
    prog_len = 4'd1;
    timeout_limit = 16'd10;
    resp_delay = 0;
    exp_q.push_back({8'h01, 2'd0});
    pulse_start();
    hi = 0; dn = 0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      if (stage_en != 8'h00) hi++;
      if (done) dn++;
      if (k == 11) begin
        chk("tmo error", {31'h0, error}, 32'h1);
        chk("tmo stage_en", {24'h0, stage_en}, 32'h0);
        chk("tmo busy", {31'h0, busy}, 32'h0);
      end
    end
    chk("tmo enabled cycles", hi, 32'd10);
    chk("tmo no done", dn, 32'd0);
    timeout_limit = '0;
    resp_delay = 4;
    exp_q.push_back({8'h01, 2'd0});
    pulse_start();
    chk("restart clears error", {31'h0, error}, 32'h0);
    wait_done("tmo rerun");

    // Abort during slot 1
    load(vecs[0].prog, 3);
    prog_len = 4'd3;
    exp_q.push_back({8'h01, 2'd0});
    exp_q.push_back({8'h02, 2'd0});
    pulse_start();
    n = 0;
    while (!(pc == 3'd1 && stage_en != 8'h00) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort reached slot1", {31'h0, (n < 50)}, 32'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort stage_en", {24'h0, stage_en}, 32'h0);
    chk("abort busy", {31'h0, busy}, 32'h0);
    chk("abort error", {31'h0, error}, 32'h0);
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("abort no done", dn, 32'd0);
    chk("abort scoreboard", exp_q.size(), 32'h0);

    // Stray done bit and host writes while busy
    stray_en = 1'b1;
    push_exp(vecs[0]);
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_wdata = 5'b00111;
      @(negedge clk);
    end
    cfg_we = 1'b0;
    wait_done("stray/write run1");
    push_exp(vecs[0]);
    pulse_start();
    wait_done("stray/write run2");
    stray_en = 1'b0;

    // Systolic opcode, then asynchronous reset mid-run
    load({10'b0, 5'b10111}, 1);
    prog_len = 4'd1;
    resp_delay = 0;
    exp_q.push_back({8'h80, 2'd2});
    pulse_start();
    @(negedge clk);
    chk("sys stage_en", {24'h0, stage_en}, 32'h80);
    chk("sys op", {30'h0, systolic_op}, 32'h2);
    chk("sys busy", {31'h0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst stage_en", {24'h0, stage_en}, 32'h0);
    chk("async rst op/pc", {27'h0, pc, systolic_op}, 32'h0);
    chk("async rst busy/done/error", {29'h0, busy, done, error}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_delay = 4;
    exp_q.push_back({8'h01, 2'd0});
    pulse_start();
    wait_done("program cleared by reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
